// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter.
// One full-adder slice and one carry flop handle one bit per clock, starting at the LSB.
module twos_to_signmag_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nxt, sgn_lat, bit_out;
  logic             accept, last;

  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    fa = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

  // Negative operands are negated as ~A + 1, with the +1 entering as the initial carry.
  always_comb begin
    accept = start && ((state == IDLE) || (state == DONE));
    last   = (cnt == CW'(WIDTH - 1));
    if (sgn_lat) begin
      {carry_nxt, bit_out} = fa(~sr[0], 1'b0, carry);
    end else begin
      carry_nxt = carry;
      bit_out   = sr[0];
    end
    acc_nxt = {bit_out, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sgn_lat <= 1'b0;
      sign    <= 1'b0;
      mag     <= '0;
    end else if (accept) begin
      sr      <= A;
      sgn_lat <= A[WIDTH-1];
      carry   <= 1'b1;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      sr    <= {1'b0, sr[WIDTH-1:1]};
      acc   <= acc_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + 1'b1;
      // Published outputs move only on the completion edge.
      if (last) begin
        mag  <= acc_nxt;
        sign <= sgn_lat;
      end
    end
  end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed self-checking bench for twos_to_signmag_serial (WIDTH = 8).
module tb_twos_to_signmag_serial;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = 8'h00;
  logic       busy, done, sign;
  logic [7:0] mag;

  int n_chk = 0;
  int n_fail = 0;

  twos_to_signmag_serial #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A),
    .busy(busy), .done(done), .sign(sign), .mag(mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Single conversion with start held for one accepting edge; checks timing and result.
  task automatic convert(input string tag, input logic [7:0] a,
                         input logic exp_s, input logic [7:0] exp_m);
    int edges, bc;
    logic stable, both;
    logic [7:0] old_m;
    logic old_s;
    old_m = mag; old_s = sign;
    @(negedge clk); start = 1'b1; A = a;
    @(posedge clk); #1 start = 1'b0; A = 8'h00;
    @(negedge clk);
    edges = 0; bc = 0; stable = 1'b1; both = 1'b0;
    while (!done && edges < 30) begin
      if (busy) bc++;
      if (busy && (mag !== old_m || sign !== old_s)) stable = 1'b0;
      @(negedge clk); edges++;
      if (busy && done) both = 1'b1;
    end
    chk({tag, "_done_edge"}, 8'(edges), 8'd8);
    chk({tag, "_busy_cycles"}, 8'(bc), 8'd8);
    chk({tag, "_hold"}, {7'd0, stable}, 8'd1);
    chk({tag, "_busy_and_done"}, {7'd0, both}, 8'd0);
    chk({tag, "_sign"}, {7'd0, sign}, {7'd0, exp_s});
    chk({tag, "_mag"}, mag, exp_m);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
  endtask

  initial begin : main
    int edges, bc, nd;
    logic [7:0] cur;

    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_sign", {7'd0, sign}, 8'd0);
    chk("rst_mag", mag, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    convert("fb", 8'hFB, 1'b1, 8'h05);
    convert("05", 8'h05, 1'b0, 8'h05);
    convert("00", 8'h00, 1'b0, 8'h00);
    convert("80", 8'h80, 1'b1, 8'h80);
    convert("ff", 8'hFF, 1'b1, 8'h01);
    convert("7f", 8'h7F, 1'b0, 8'h7F);

    // Start during SHIFT must be ignored.
    @(negedge clk); start = 1'b1; A = 8'hF6;
    @(posedge clk); #1 start = 1'b0;
    bc = 0; nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) nd++;
      if (bc == 4 && busy && i < 8) begin
        start = 1'b1; A = 8'h03;
        @(posedge clk); #1 start = 1'b0;
        bc++;
      end
      if (done) begin
        chk("ign_sign", {7'd0, sign}, 8'd1);
        chk("ign_mag", mag, 8'h0A);
      end
    end
    chk("ign_done_count", 8'(nd), 8'd1);
    chk("ign_idle", {7'd0, busy}, 8'd0);

    // Back-to-back with start held high, alternating operands at each done.
    @(negedge clk); start = 1'b1; A = 8'h9C; cur = 8'h9C;
    edges = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); edges = 1;
      while (!done && edges < 30) begin @(negedge clk); edges++; end
      if (k > 0) chk("b2b_period", 8'(edges), 8'd9);
      chk("b2b_sign", {7'd0, sign}, (cur == 8'h9C) ? 8'd1 : 8'd0);
      chk("b2b_mag", mag, 8'h64);
      cur = (cur == 8'h9C) ? 8'h64 : 8'h9C;
      A = cur;
      if (k == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_stop", {7'd0, busy}, 8'd0);

    // Asynchronous reset between edges in the middle of a conversion.
    @(negedge clk); start = 1'b1; A = 8'h85;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_done", {7'd0, done}, 8'd0);
    chk("arst_sign", {7'd0, sign}, 8'd0);
    chk("arst_mag", mag, 8'h00);
    @(negedge clk); reset = 1'b0;
    convert("c0", 8'hC0, 1'b1, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
